// File: rtl/cgra_clock_gate_ctrl.sv
// Clock-gate enable controller for a CGRA: sequences OFF -> WAKE -> ON -> DRAIN -> OFF.
// en_o comes straight from a flop so it can drive a latch-based gate cell glitch-free.
module cgra_clock_gate_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned DRAIN_CYCLES  = 2,
  parameter int unsigned IDLE_W        = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wake_req_i,
  output logic              wake_ack_o,
  input  logic              sleep_req_i,
  input  logic              busy_i,
  input  logic              force_en_i,
  input  logic [IDLE_W-1:0] idle_thr_i,
  output logic              en_o,
  output logic              gated_o,
  output logic [1:0]        state_o
);

  localparam int unsigned SettleW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned DrainW  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);
  localparam logic [SettleW-1:0] SettleOne  = SettleW'(1);
  localparam logic [DrainW-1:0]  DrainLast  = DrainW'(DRAIN_CYCLES - 1);
  localparam logic [DrainW-1:0]  DrainOne   = DrainW'(1);
  localparam logic [IDLE_W-1:0]  IdleOne    = IDLE_W'(1);

  typedef enum logic [1:0] {
    StOff   = 2'd0,
    StWake  = 2'd1,
    StOn    = 2'd2,
    StDrain = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                en_q, en_d;
  logic                ack_q, ack_d;
  logic [SettleW-1:0]  settle_q, settle_d;
  logic [DrainW-1:0]   drain_q, drain_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;

  logic keep_on;
  logic idle_cycle;
  logic idle_hit;

  assign keep_on    = wake_req_i | force_en_i;
  assign idle_cycle = ~busy_i & ~wake_req_i;
  // Exact match only, so a threshold lowered below the live count waits for the next clear.
  assign idle_hit   = (idle_thr_i != '0) && idle_cycle && (idle_q == (idle_thr_i - IdleOne));

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    drain_d  = drain_q;
    idle_d   = idle_q;
    ack_d    = 1'b0;

    unique case (state_q)
      StOff: begin
        if (keep_on) begin
          state_d  = StWake;
          settle_d = '0;
        end
      end
      StWake: begin
        if (settle_q == SettleLast) begin
          state_d = StOn;
          idle_d  = '0;
        end else begin
          settle_d = settle_q + SettleOne;
        end
      end
      StOn: begin
        ack_d = wake_req_i & ~ack_q;
        if (!idle_cycle) begin
          idle_d = '0;
        end else if (idle_q != '1) begin
          idle_d = idle_q + IdleOne;
        end
        if (!keep_on && !busy_i && (sleep_req_i || idle_hit)) begin
          state_d = StDrain;
          drain_d = '0;
        end
      end
      StDrain: begin
        if (keep_on || busy_i) begin
          state_d = StOn;
          idle_d  = '0;
        end else if (drain_q == DrainLast) begin
          state_d = StOff;
        end else begin
          drain_d = drain_q + DrainOne;
        end
      end
      default: state_d = StOff;
    endcase

    en_d = (state_d != StOff);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StOff;
      en_q     <= 1'b0;
      ack_q    <= 1'b0;
      settle_q <= '0;
      drain_q  <= '0;
      idle_q   <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      ack_q    <= ack_d;
      settle_q <= settle_d;
      drain_q  <= drain_d;
      idle_q   <= idle_d;
    end
  end

  assign en_o       = en_q;
  assign wake_ack_o = ack_q;
  assign gated_o    = (state_q == StOff);
  assign state_o    = state_q;

endmodule

// File: tb/tb_cgra_clock_gate_ctrl.sv
// Directed bench for cgra_clock_gate_ctrl with default parameters (SETTLE=2, DRAIN=2, IDLE_W=8).
module tb_cgra_clock_gate_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       wake_req_i = 1'b0;
  logic       wake_ack_o;
  logic       sleep_req_i = 1'b0;
  logic       busy_i = 1'b0;
  logic       force_en_i = 1'b0;
  logic [7:0] idle_thr_i = 8'd0;
  logic       en_o;
  logic       gated_o;
  logic [1:0] state_o;

  int n_cmp = 0;
  int n_bad = 0;

  cgra_clock_gate_ctrl dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .wake_req_i (wake_req_i),
    .wake_ack_o (wake_ack_o),
    .sleep_req_i(sleep_req_i),
    .busy_i     (busy_i),
    .force_en_i (force_en_i),
    .idle_thr_i (idle_thr_i),
    .en_o       (en_o),
    .gated_o    (gated_o),
    .state_o    (state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #3;
    n_cmp++; if (state_o !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state_o); end
    n_cmp++; if (en_o !== 1'b0) begin n_bad++; $display("FAIL reset_en: got %b want 0", en_o); end
    n_cmp++; if (gated_o !== 1'b1) begin n_bad++; $display("FAIL reset_gated: got %b want 1", gated_o); end
    n_cmp++; if (wake_ack_o !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", wake_ack_o); end
    tick();
    rst_ni = 1'b1;
  endtask

  // Full wake handshake from OFF: WAKE after edge 0, ON after edge 2, ack after edge 3.
  task automatic test_wake(input string tag);
    wake_req_i = 1'b1;
    tick();
    n_cmp++; if (en_o !== 1'b1 || state_o !== 2'd1) begin
      n_bad++; $display("FAIL %s_edge0: en=%b state=%0d want en=1 state=1", tag, en_o, state_o); end
    tick();
    n_cmp++; if (state_o !== 2'd1 || wake_ack_o !== 1'b0) begin
      n_bad++; $display("FAIL %s_edge1: state=%0d ack=%b want 1/0", tag, state_o, wake_ack_o); end
    tick();
    n_cmp++; if (state_o !== 2'd2 || wake_ack_o !== 1'b0) begin
      n_bad++; $display("FAIL %s_edge2: state=%0d ack=%b want 2/0", tag, state_o, wake_ack_o); end
    tick();
    n_cmp++; if (wake_ack_o !== 1'b1) begin
      n_bad++; $display("FAIL %s_edge3_ack: got %b want 1", tag, wake_ack_o); end
    wake_req_i = 1'b0;
    tick();
    n_cmp++; if (wake_ack_o !== 1'b0 || state_o !== 2'd2) begin
      n_bad++; $display("FAIL %s_after_ack: ack=%b state=%0d want 0/2", tag, wake_ack_o, state_o); end
  endtask

  task automatic test_hold_ack();
    logic exp [3] = '{1'b1, 1'b0, 1'b1};
    wake_req_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (wake_ack_o !== exp[i]) begin
        n_bad++; $display("FAIL hold_ack[%0d]: got %b want %b", i, wake_ack_o, exp[i]); end
    end
    wake_req_i = 1'b0;
    tick();
    n_cmp++; if (wake_ack_o !== 1'b0) begin n_bad++; $display("FAIL hold_ack_drop: got %b want 0", wake_ack_o); end
  endtask

  task automatic test_auto_gate();
    busy_i = 1'b1;
    tick();
    busy_i = 1'b0;
    idle_thr_i = 8'd4;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (state_o !== 2'd2) begin n_bad++; $display("FAIL auto_idle[%0d]: state=%0d want 2", i, state_o); end
    end
    tick();
    n_cmp++; if (state_o !== 2'd3 || en_o !== 1'b1) begin
      n_bad++; $display("FAIL auto_drain: state=%0d en=%b want 3/1", state_o, en_o); end
    tick();
    n_cmp++; if (state_o !== 2'd3 || en_o !== 1'b1) begin
      n_bad++; $display("FAIL auto_drain2: state=%0d en=%b want 3/1", state_o, en_o); end
    tick();
    n_cmp++; if (state_o !== 2'd0 || en_o !== 1'b0 || gated_o !== 1'b1) begin
      n_bad++; $display("FAIL auto_off: state=%0d en=%b gated=%b want 0/0/1", state_o, en_o, gated_o); end
    idle_thr_i = 8'd0;
  endtask

  task automatic test_drain_abort();
    test_wake("abort_wake");
    sleep_req_i = 1'b1;
    tick();
    sleep_req_i = 1'b0;
    n_cmp++; if (state_o !== 2'd3) begin n_bad++; $display("FAIL abort_enter: state=%0d want 3", state_o); end
    busy_i = 1'b1;
    tick();
    busy_i = 1'b0;
    n_cmp++; if (state_o !== 2'd2 || en_o !== 1'b1 || wake_ack_o !== 1'b0) begin
      n_bad++; $display("FAIL abort_on: state=%0d en=%b ack=%b want 2/1/0", state_o, en_o, wake_ack_o); end
    idle_thr_i = 8'd2;
    tick();
    n_cmp++; if (state_o !== 2'd2) begin n_bad++; $display("FAIL abort_idle1: state=%0d want 2", state_o); end
    tick();
    n_cmp++; if (state_o !== 2'd3) begin n_bad++; $display("FAIL abort_idle2: state=%0d want 3", state_o); end
    idle_thr_i = 8'd0;
    tick();
    tick();
    n_cmp++; if (state_o !== 2'd0) begin n_bad++; $display("FAIL abort_off: state=%0d want 0", state_o); end
  endtask

  task automatic test_force();
    int bad = 0;
    force_en_i = 1'b1;
    tick();
    tick();
    tick();
    sleep_req_i = 1'b1;
    idle_thr_i = 8'd1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (en_o !== 1'b1 || state_o !== 2'd2) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL force_hold: %0d bad cycles want 0", bad); end
    force_en_i = 1'b0;
    tick();
    n_cmp++; if (state_o !== 2'd3) begin n_bad++; $display("FAIL force_release: state=%0d want 3", state_o); end
    sleep_req_i = 1'b0;
    idle_thr_i = 8'd0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_wake();
    n_cmp++; if (state_o !== 2'd0) begin n_bad++; $display("FAIL rst_pre_off: state=%0d want 0", state_o); end
    wake_req_i = 1'b1;
    tick();
    #2;
    rst_ni = 1'b0;
    #1;
    n_cmp++; if (en_o !== 1'b0 || state_o !== 2'd0) begin
      n_bad++; $display("FAIL rst_async: en=%b state=%0d want 0/0", en_o, state_o); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (wake_ack_o !== 1'b0 || state_o !== 2'd0) begin
        n_bad++; $display("FAIL rst_hold[%0d]: ack=%b state=%0d want 0/0", i, wake_ack_o, state_o); end
    end
    rst_ni = 1'b1;
    test_wake("rst_rewake");
  endtask

  task automatic test_live_thr();
    for (int i = 0; i < 10; i++) tick();
    idle_thr_i = 8'd5;
    for (int i = 0; i < 6; i++) tick();
    n_cmp++; if (state_o !== 2'd2) begin n_bad++; $display("FAIL live_thr_below: state=%0d want 2", state_o); end
    busy_i = 1'b1;
    tick();
    busy_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if (state_o !== 2'd2) begin n_bad++; $display("FAIL live_thr_4: state=%0d want 2", state_o); end
    tick();
    n_cmp++; if (state_o !== 2'd3) begin n_bad++; $display("FAIL live_thr_5: state=%0d want 3", state_o); end
    idle_thr_i = 8'd0;
    tick();
    tick();
  endtask

  task automatic test_thr_zero();
    int bad = 0;
    idle_thr_i = 8'd0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (state_o !== 2'd2 || en_o !== 1'b1) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL thr0_hold: %0d bad cycles want 0", bad); end
    sleep_req_i = 1'b1;
    tick();
    sleep_req_i = 1'b0;
    n_cmp++; if (state_o !== 2'd3) begin n_bad++; $display("FAIL thr0_drain: state=%0d want 3", state_o); end
    tick();
    tick();
    n_cmp++; if (state_o !== 2'd0 || en_o !== 1'b0) begin
      n_bad++; $display("FAIL thr0_off: state=%0d en=%b want 0/0", state_o, en_o); end
  endtask

  initial begin
    test_reset();
    test_wake("wake");
    test_hold_ack();
    test_auto_gate();
    test_drain_abort();
    test_force();
    test_reset_mid_wake();
    test_live_thr();
    test_wake("wake2");
    test_thr_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
